// File: rtl/packet_bank_tx.sv
// Bank-buffered serial transmitter: host fills a word buffer, start sends it as one sos/bits/eos frame.
// Optional PACKET_TX_PARITY_EN appends an even-parity bit after every word's LSB.
module packet_bank_tx #(
    parameter int unsigned BW_MEM = 16,
    parameter int unsigned DEPTH  = 256,
    localparam int unsigned CW    = $clog2(DEPTH + 1),
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_valid,
    input  logic [BW_MEM-1:0] wr_data,
    output logic              wr_ready,
    input  logic              clear,
    input  logic              start,
    input  logic              abort,
    output logic              ser_data,
    output logic              sos,
    output logic              eos,
    output logic              busy,
    output logic              done,
    output logic [CW-1:0]     word_count
);

`ifdef PACKET_TX_PARITY_EN
    localparam int unsigned PAR_W = 1;
`else
    localparam int unsigned PAR_W = 0;
`endif
    localparam int unsigned WP  = BW_MEM + PAR_W;
    localparam int unsigned BCW = (WP > 1) ? $clog2(WP) : 1;

    typedef enum logic [2:0] {IDLE, SOS, SHIFT, EOS, DONE} state_t;

    state_t            state, state_nxt;
    logic [AW-1:0]     wptr, wptr_nxt, rptr, rptr_nxt, rd_addr;
    logic [CW-1:0]     wc_nxt;
    logic [BCW-1:0]    bit_cnt, bit_cnt_nxt;
    logic [BW_MEM-1:0] shreg, shreg_nxt, rd_word;
    logic              wr_en;
    logic              ser_nxt, sos_nxt, eos_nxt, busy_nxt, done_nxt, wr_ready_nxt;
`ifdef PACKET_TX_PARITY_EN
    logic              par, par_nxt;
`endif

    logic [BW_MEM-1:0] mem [DEPTH];

    // Buffer storage; contents survive reset and frames so a later start replays them.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr] <= wr_data;
    end

    // Fetch the word that gets loaded into the shifter on the next edge.
    assign rd_addr = (state == SHIFT) ? rptr + AW'(1) : '0;
    assign rd_word = mem[rd_addr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            wptr       <= '0;
            rptr       <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            word_count <= '0;
            ser_data   <= 1'b0;
            sos        <= 1'b0;
            eos        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            wr_ready   <= 1'b1;
`ifdef PACKET_TX_PARITY_EN
            par        <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            wptr       <= wptr_nxt;
            rptr       <= rptr_nxt;
            bit_cnt    <= bit_cnt_nxt;
            shreg      <= shreg_nxt;
            word_count <= wc_nxt;
            ser_data   <= ser_nxt;
            sos        <= sos_nxt;
            eos        <= eos_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            wr_ready   <= wr_ready_nxt;
`ifdef PACKET_TX_PARITY_EN
            par        <= par_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt   = state;
        wptr_nxt    = wptr;
        rptr_nxt    = rptr;
        wc_nxt      = word_count;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        wr_en       = 1'b0;
        ser_nxt     = 1'b0;
        sos_nxt     = 1'b0;
        eos_nxt     = 1'b0;
        done_nxt    = 1'b0;
`ifdef PACKET_TX_PARITY_EN
        par_nxt     = par;
`endif
        unique case (state)
            IDLE: begin
                if (clear) begin
                    wc_nxt   = '0;
                    wptr_nxt = '0;
                end else if (wr_valid && wr_ready) begin
                    wr_en    = 1'b1;
                    wptr_nxt = wptr + AW'(1);
                    wc_nxt   = word_count + CW'(1);
                end
                if (start) begin
                    // A clear in the same cycle empties the buffer first.
                    if (clear || (word_count == '0)) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt   = SOS;
                        sos_nxt     = 1'b1;
                        rptr_nxt    = '0;
                        bit_cnt_nxt = '0;
                    end
                end
            end
            SOS: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt   = SHIFT;
                    rptr_nxt    = '0;
                    bit_cnt_nxt = '0;
                    ser_nxt     = rd_word[BW_MEM-1];
                    shreg_nxt   = rd_word << 1;
`ifdef PACKET_TX_PARITY_EN
                    par_nxt     = ^rd_word;
`endif
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (bit_cnt == BCW'(WP - 1)) begin
                    if (CW'(rptr) == (word_count - CW'(1))) begin
                        state_nxt = EOS;
                        eos_nxt   = 1'b1;
                    end else begin
                        rptr_nxt    = rptr + AW'(1);
                        bit_cnt_nxt = '0;
                        ser_nxt     = rd_word[BW_MEM-1];
                        shreg_nxt   = rd_word << 1;
`ifdef PACKET_TX_PARITY_EN
                        par_nxt     = ^rd_word;
`endif
                    end
                end else begin
                    bit_cnt_nxt = bit_cnt + BCW'(1);
`ifdef PACKET_TX_PARITY_EN
                    if (bit_cnt == BCW'(BW_MEM - 1)) begin
                        ser_nxt = par;
                    end else begin
                        ser_nxt   = shreg[BW_MEM-1];
                        shreg_nxt = shreg << 1;
                    end
`else
                    ser_nxt   = shreg[BW_MEM-1];
                    shreg_nxt = shreg << 1;
`endif
                end
            end
            EOS: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        busy_nxt     = (state_nxt == SOS) || (state_nxt == SHIFT) || (state_nxt == EOS);
        wr_ready_nxt = (state_nxt == IDLE) && (wc_nxt < CW'(DEPTH));
    end

endmodule

// File: tb/tb_packet_bank_tx.sv
// Scoreboard bench for packet_bank_tx: stimulus queues per-cycle expected stream, a negedge monitor checks it.
module tb_packet_bank_tx;
    localparam int unsigned BW    = 16;
    localparam int unsigned DEPTH = 256;
    localparam int unsigned CW    = 9;

    typedef struct packed {
        logic sos;
        logic eos;
        logic ser;
        logic busy;
        logic done;
    } obs_t;

    logic          clk;
    logic          reset;
    logic          wr_valid;
    logic [BW-1:0] wr_data;
    logic          wr_ready;
    logic          clear;
    logic          start;
    logic          abort;
    logic          ser_data;
    logic          sos;
    logic          eos;
    logic          busy;
    logic          done;
    logic [CW-1:0] word_count;

    obs_t          exp_q[$];
    logic [BW-1:0] model_q[$];
    obs_t          mon_o;
    obs_t          mon_e;
    int            n_vec  = 0;
    int            n_fail = 0;

    packet_bank_tx #(.BW_MEM(BW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .clear      (clear),
        .start      (start),
        .abort      (abort),
        .ser_data   (ser_data),
        .sos        (sos),
        .eos        (eos),
        .busy       (busy),
        .done       (done),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t mk(input logic s, input logic e, input logic d, input logic b, input logic dn);
        obs_t o;
        o.sos  = s;
        o.eos  = e;
        o.ser  = d;
        o.busy = b;
        o.done = dn;
        return o;
    endfunction

    // Expected cycle-by-cycle frame for the current buffer model.
    task automatic push_frame();
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
        foreach (model_q[k]) begin
            for (int i = BW - 1; i >= 0; i--) exp_q.push_back(mk(1'b0, 1'b0, model_q[k][i], 1'b1, 1'b0));
`ifdef PACKET_TX_PARITY_EN
            exp_q.push_back(mk(1'b0, 1'b0, ^model_q[k], 1'b1, 1'b0));
`endif
        end
        exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [BW-1:0] w);
        wr_valid = 1'b1;
        wr_data  = w;
        if (model_q.size() < DEPTH) model_q.push_back(w);
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic do_start();
        if (model_q.size() > 0) push_frame();
        else exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic drain(input int budget, input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: %0d expected cycles never seen within %0d cycles", name, exp_q.size(), budget);
            exp_q.delete();
        end
        tick();
    endtask

    // Monitor: every busy/done cycle must match the head of the expected queue; idle cycles stay quiet.
    always @(negedge clk) begin
        if (reset) begin
            mon_o = mk(sos, eos, ser_data, busy, done);
            n_vec++;
            if (busy || done) begin
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL stream: got %b with nothing expected", mon_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_o !== mon_e) begin
                        n_fail++;
                        $display("FAIL stream: got %b, expected %b (%0d left)", mon_o, mon_e, exp_q.size());
                    end
                end
            end else if ({sos, eos, ser_data} !== 3'b000) begin
                n_fail++;
                $display("FAIL idle_quiet: sos/eos/ser %b, expected 000", {sos, eos, ser_data});
            end
        end
    end

    initial begin
        reset    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = '0;
        clear    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sos", 32'(sos), 32'd0);
        chk("rst_eos", 32'(eos), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ser", 32'(ser_data), 32'd0);
        chk("rst_count", 32'(word_count), 32'd0);
        reset = 1'b1;
        tick();
        chk("wr_ready_idle", 32'(wr_ready), 32'd1);

        // Two-word frame: 1010010111000011 then 0000000000000001.
        write_word(16'hA5C3);
        write_word(16'h0001);
        chk("count_two", 32'(word_count), 32'd2);
        do_start();
        chk("wr_ready_busy", 32'(wr_ready), 32'd0);
        chk("busy_sos", 32'(busy), 32'd1);
        wr_valid = 1'b1;
        wr_data  = 16'hFFFF;
        tick();
        wr_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        drain(200, "frame_two");
        chk("count_after_frame", 32'(word_count), 32'd2);

        // Replay of the same buffer.
        do_start();
        drain(200, "replay");
        chk("count_after_replay", 32'(word_count), 32'd2);

        // Abort sampled at T+10: sos plus nine bits of 0xA5C3, then silence.
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
        for (int i = 0; i < 9; i++) exp_q.push_back(mk(1'b0, 1'b0, model_q[0][BW-1-i], 1'b1, 1'b0));
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ser", 32'(ser_data), 32'd0);
        chk("abort_eos", 32'(eos), 32'd0);
        repeat (5) tick();
        chk("abort_q_empty", 32'(exp_q.size()), 32'd0);
        chk("abort_count", 32'(word_count), 32'd2);

        // Clear beats a same-cycle write.
        clear    = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 16'h1234;
        tick();
        clear    = 1'b0;
        wr_valid = 1'b0;
        model_q.delete();
        chk("clear_count", 32'(word_count), 32'd0);

        // Empty start gives only a done pulse.
        do_start();
        drain(10, "empty_start");

        // start+clear acts as an empty-buffer start.
        write_word(16'h00FF);
        chk("count_one", 32'(word_count), 32'd1);
        model_q.delete();
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        clear = 1'b1;
        start = 1'b1;
        tick();
        clear = 1'b0;
        start = 1'b0;
        drain(10, "start_clear");
        chk("start_clear_count", 32'(word_count), 32'd0);

        // Single word 0x0007 (parity bit 1 when enabled).
        write_word(16'h0007);
        do_start();
        drain(100, "word_0007");
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_q.delete();

        // Full buffer, refused overflow write, full-length frame.
        for (int i = 0; i < 256; i++) write_word(BW'(i * 37 + 11) ^ 16'hC0DE);
        chk("full_ready", 32'(wr_ready), 32'd0);
        write_word(16'hDEAD);
        chk("full_count", 32'(word_count), 32'd256);
        do_start();
        drain(5000, "full_frame");
        chk("full_count_after", 32'(word_count), 32'd256);

        // Asynchronous reset in the middle of SHIFT.
        do_start();
        repeat (40) tick();
        #1;
        reset = 1'b0;
        #1;
        exp_q.delete();
        model_q.delete();
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_ser", 32'(ser_data), 32'd0);
        chk("midrst_sos_eos", 32'({sos, eos}), 32'd0);
        chk("midrst_count", 32'(word_count), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        do_start();
        drain(10, "post_reset_empty");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
